// File: rtl/tile_recorder.sv
// tile_recorder: records button presses into a chart, one 3-bit row per beat.
// Optional macro REC_DEBOUNCE_EN requires three consecutive low samples per press.
`default_nettype none

module tile_recorder #(
    parameter int BEAT_DIV   = 50000000,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEPTH      = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    input  logic       start,
    input  logic [6:0] rd_addr,
    output logic [2:0] rd_data,
    output logic       rec_busy,
    output logic       rec_done,
    output logic [6:0] wr_count,
    output logic       beat_tick
);

    localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [BW-1:0] BEAT_LAST   = BW'(BEAT_DIV - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [6:0]    ROW_LAST    = 7'(DEPTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECORD = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state;
    logic [BW-1:0] beat_cnt;
    logic [SW-1:0] sample_cnt;
    logic [2:0]    hit;
    logic [2:0]    mem [0:DEPTH-1];

    logic       in_rec;
    logic       start_rec;
    logic       sample_tick;
    logic       beat_end;
    logic [2:0] lane_low;
    logic [2:0] qual;
    logic [2:0] press;

    assign in_rec      = (state == S_RECORD);
    assign start_rec   = start && !in_rec;
    assign sample_tick = in_rec && (sample_cnt == SAMPLE_LAST);
    assign beat_end    = in_rec && (beat_cnt == BEAT_LAST);
    assign lane_low    = ~{btn1, btn2, btn3};
    assign press       = sample_tick ? qual : 3'b000;

    assign rec_busy = in_rec;
    assign rec_done = (state == S_DONE);

`ifdef REC_DEBOUNCE_EN
    // run[i] counts previous consecutive low ticks, capped at 2
    logic [2:0][1:0] run;

    always_ff @(posedge clk) begin
        if (rst || start_rec) begin
            run <= '0;
        end else if (sample_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (!lane_low[i])
                    run[i] <= 2'd0;
                else if (run[i] != 2'd2)
                    run[i] <= run[i] + 2'd1;
            end
        end
    end

    always_comb begin
        qual = 3'b000;
        for (int i = 0; i < 3; i++)
            qual[i] = lane_low[i] && (run[i] == 2'd2);
    end
`else
    assign qual = lane_low;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            sample_cnt <= '0;
            hit        <= 3'b000;
            wr_count   <= 7'd0;
            beat_tick  <= 1'b0;
            rd_data    <= 3'b000;
        end else begin
            beat_tick <= beat_end;
            // wr_count hides stale rows, including those from a previous recording
            rd_data   <= (rd_addr < wr_count) ? mem[rd_addr[AW-1:0]] : 3'b000;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RECORD;
                        beat_cnt   <= '0;
                        sample_cnt <= '0;
                        hit        <= 3'b000;
                        wr_count   <= 7'd0;
                    end
                end
                S_RECORD: begin
                    sample_cnt <= sample_tick ? '0 : sample_cnt + 1'b1;
                    beat_cnt   <= beat_end ? '0 : beat_cnt + 1'b1;
                    if (beat_end) begin
                        hit      <= 3'b000;
                        wr_count <= wr_count + 7'd1;
                        if (wr_count == ROW_LAST)
                            state <= S_DONE;
                    end else begin
                        hit <= hit | press;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Same-cycle sample press belongs to the ending beat
    always_ff @(posedge clk) begin
        if (!rst && beat_end)
            mem[wr_count[AW-1:0]] <= hit | press;
    end

endmodule

`default_nettype wire
